// File: rtl/dm_runctl_pkg.sv
// Shared types and defaults for the debug-module hart run-control sequencer.
package dm_runctl_pkg;

  localparam int unsigned DEF_NUM_HARTS      = 4;
  localparam int unsigned DEF_HARTSEL_W      = 10;
  localparam int unsigned DEF_RESUME_TIMEOUT = 1023;
  localparam int unsigned CNT_W              = 16;

  typedef enum logic [1:0] {
    RUNNING     = 2'd0,
    HALT_PEND   = 2'd1,
    HALTED      = 2'd2,
    RESUME_PEND = 2'd3
  } run_state_e;

  typedef struct packed {
    logic anyhalted;
    logic allhalted;
    logic anyrunning;
    logic allrunning;
    logic anyresumeack;
    logic allresumeack;
  } summary_t;

  // A hart waiting on a resume acknowledge is still halted from the debugger's view.
  function automatic logic is_halted(input run_state_e s);
    return (s == HALTED) || (s == RESUME_PEND);
  endfunction

endpackage

// File: rtl/dm_hart_runctl_slot.sv
// Per-hart run-control FSM: haltreq latch, resume request/ack handshake and
// resume timeout detection.
module dm_hart_runctl_slot
  import dm_runctl_pkg::*;
#(
  parameter int unsigned RESUME_TIMEOUT = DEF_RESUME_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dmactive,
  input  logic       cmd_hit,
  input  logic       cmd_haltreq,
  input  logic       cmd_resumereq,
  input  logic       hart_halted,
  output logic       debug_int,
  output logic       resume_req,
  output logic       resumeack,
  output logic       timeout,
  output run_state_e state
);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haltreq_q, haltreq_d;
  logic             resume_req_q, resume_req_d;
  logic             resumeack_q, resumeack_d;
  logic             resume_go, resume_done, resume_to;

  // Commands are judged against the registered state, never the next one.
  assign resume_go   = cmd_hit && !cmd_haltreq && cmd_resumereq && (state_q == HALTED);
  assign resume_done = (state_q == RESUME_PEND) && !hart_halted;
  assign resume_to   = (state_q == RESUME_PEND) && hart_halted &&
                       (cnt_q >= CNT_W'(RESUME_TIMEOUT - 1));

  // NOTE: every flop here is a few bits of control, so all of them take the async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUNNING;
      cnt_q        <= '0;
      haltreq_q    <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      haltreq_q    <= haltreq_d;
      resume_req_q <= resume_req_d;
      resumeack_q  <= resumeack_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!dmactive) begin
      state_d = hart_halted ? HALTED : RUNNING;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUNNING: begin
          if (cmd_hit && cmd_haltreq) state_d = HALT_PEND;
          else if (hart_halted)       state_d = HALTED;
        end
        HALT_PEND: begin
          if (hart_halted)     state_d = HALTED;
          else if (!haltreq_q) state_d = RUNNING;
        end
        HALTED: begin
          if (resume_go) begin
            state_d = RESUME_PEND;
            cnt_d   = '0;
          end else if (!hart_halted) begin
            state_d = RUNNING;
          end
        end
        RESUME_PEND: begin
          if (resume_done)          state_d = RUNNING;
          else if (resume_to)       state_d = HALTED;
          else if (cnt_q != '1)     cnt_d   = cnt_q + CNT_W'(1);
        end
      endcase
    end
  end

  always_comb begin
    haltreq_d    = haltreq_q;
    resume_req_d = resume_req_q;
    resumeack_d  = resumeack_q;
    timeout      = 1'b0;
    if (!dmactive) begin
      haltreq_d    = 1'b0;
      resume_req_d = 1'b0;
      resumeack_d  = 1'b0;
    end else begin
      if (cmd_hit) haltreq_d = cmd_haltreq;
      if (resume_go) begin
        resume_req_d = 1'b1;
        resumeack_d  = 1'b0;
      end
      if (resume_done) begin
        resume_req_d = 1'b0;
        resumeack_d  = 1'b1;
      end
      if (resume_to) begin
        resume_req_d = 1'b0;
        timeout      = 1'b1;
      end
    end
  end

  assign debug_int  = haltreq_q;
  assign resume_req = resume_req_q;
  assign resumeack  = resumeack_q;
  assign state      = state_q;

endmodule

// File: rtl/dm_hart_runctl.sv
// Debug Module run-control: decodes DMCONTROL selections into per-hart slots
// and builds the registered DMSTATUS summary bits.
module dm_hart_runctl
  import dm_runctl_pkg::*;
#(
  parameter int unsigned NUM_HARTS      = DEF_NUM_HARTS,
  parameter int unsigned HARTSEL_W      = DEF_HARTSEL_W,
  parameter int unsigned RESUME_TIMEOUT = DEF_RESUME_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dmactive,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_haltreq,
  input  logic                 cmd_resumereq,
  input  logic                 cmd_hasel,
  input  logic [HARTSEL_W-1:0] cmd_hartsel,
  input  logic [NUM_HARTS-1:0] hawindow,
  input  logic [NUM_HARTS-1:0] hart_halted,
  output logic [NUM_HARTS-1:0] debug_int,
  output logic [NUM_HARTS-1:0] resume_req,
  output logic [NUM_HARTS-1:0] resumeack,
  output logic                 anyhalted,
  output logic                 allhalted,
  output logic                 anyrunning,
  output logic                 allrunning,
  output logic                 anyresumeack,
  output logic                 allresumeack,
  output logic                 anynonexistent,
  output logic                 resume_err
);

  // Compare hartsel at no less than 32 bits so large indices never alias onto real harts.
  localparam int unsigned CMP_W = (HARTSEL_W > 32) ? HARTSEL_W : 32;

  logic                 accept;
  logic [CMP_W-1:0]     hartsel_ext;
  logic [NUM_HARTS-1:0] sel_now, hit, halted_vec, timeout_vec;
  logic [NUM_HARTS-1:0] sel_q, sel_d;
  logic                 nonexist_q, nonexist_d;
  logic                 err_q, err_d;
  summary_t             summ_q, summ_d;
  run_state_e           state_vec [NUM_HARTS];

  assign cmd_ready   = dmactive;
  assign accept      = cmd_valid & dmactive;
  assign hartsel_ext = CMP_W'(cmd_hartsel);
  assign hit         = {NUM_HARTS{accept}} & sel_now;

  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      sel_now[i]    = (hartsel_ext == CMP_W'(i)) || (cmd_hasel && hawindow[i]);
      halted_vec[i] = is_halted(state_vec[i]);
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_slot
    dm_hart_runctl_slot #(
      .RESUME_TIMEOUT(RESUME_TIMEOUT)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .dmactive     (dmactive),
      .cmd_hit      (hit[g]),
      .cmd_haltreq  (cmd_haltreq),
      .cmd_resumereq(cmd_resumereq),
      .hart_halted  (hart_halted[g]),
      .debug_int    (debug_int[g]),
      .resume_req   (resume_req[g]),
      .resumeack    (resumeack[g]),
      .timeout      (timeout_vec[g]),
      .state        (state_vec[g])
    );
  end

  always_comb begin
    sel_d      = accept ? sel_now : sel_q;
    nonexist_d = accept ? (hartsel_ext >= CMP_W'(NUM_HARTS)) : nonexist_q;
    err_d      = dmactive ? (err_q | (|timeout_vec)) : 1'b0;
  end

  // An empty selection reports zero for both the "any" and the "all" bits.
  always_comb begin
    summ_d              = '0;
    summ_d.anyhalted    = |(sel_q & halted_vec);
    summ_d.allhalted    = (|sel_q) && ((sel_q & halted_vec) == sel_q);
    summ_d.anyrunning   = |(sel_q & ~halted_vec);
    summ_d.allrunning   = (|sel_q) && ((sel_q & ~halted_vec) == sel_q);
    summ_d.anyresumeack = |(sel_q & resumeack);
    summ_d.allresumeack = (|sel_q) && ((sel_q & resumeack) == sel_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      nonexist_q <= 1'b0;
      err_q      <= 1'b0;
      summ_q     <= '0;
    end else begin
      sel_q      <= sel_d;
      nonexist_q <= nonexist_d;
      err_q      <= err_d;
      summ_q     <= summ_d;
    end
  end

  assign anyhalted      = summ_q.anyhalted;
  assign allhalted      = summ_q.allhalted;
  assign anyrunning     = summ_q.anyrunning;
  assign allrunning     = summ_q.allrunning;
  assign anyresumeack   = summ_q.anyresumeack;
  assign allresumeack   = summ_q.allresumeack;
  assign anynonexistent = nonexist_q;
  assign resume_err     = err_q;

endmodule

// File: tb/tb_dm_hart_runctl.sv
// Directed and randomized checks of dm_hart_runctl against a per-hart flag model.
module tb_dm_hart_runctl;

  localparam int NH = 4;
  localparam int T  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          dmactive, cmd_valid, cmd_ready, cmd_haltreq, cmd_resumereq, cmd_hasel;
  logic [9:0]    cmd_hartsel;
  logic [NH-1:0] hawindow, hart_halted, debug_int, resume_req, resumeack;
  logic          anyhalted, allhalted, anyrunning, allrunning, anyresumeack, allresumeack;
  logic          anynonexistent, resume_err;

  int total = 0;
  int bad   = 0;

  // Model: DM-view flags per hart plus the cycle a resume was issued.
  bit [NH-1:0] m_hreq, m_halted, m_phalt, m_pres, m_ack, m_sel;
  bit          m_nonex, m_err;
  bit [5:0]    m_sum;
  int          m_rstart [NH];
  int          cyc = 0;

  dm_hart_runctl #(.NUM_HARTS(NH), .HARTSEL_W(10), .RESUME_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .dmactive(dmactive), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_haltreq(cmd_haltreq), .cmd_resumereq(cmd_resumereq),
    .cmd_hasel(cmd_hasel), .cmd_hartsel(cmd_hartsel), .hawindow(hawindow),
    .hart_halted(hart_halted), .debug_int(debug_int), .resume_req(resume_req),
    .resumeack(resumeack), .anyhalted(anyhalted), .allhalted(allhalted),
    .anyrunning(anyrunning), .allrunning(allrunning), .anyresumeack(anyresumeack),
    .allresumeack(allresumeack), .anynonexistent(anynonexistent), .resume_err(resume_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [5:0] summarize(bit [NH-1:0] sel, bit [NH-1:0] h, bit [NH-1:0] a);
    int ns, nh, na;
    ns = $countones(sel);
    nh = $countones(sel & h);
    na = $countones(sel & a);
    return {nh > 0, (ns > 0) && (nh == ns), nh < ns, (ns > 0) && (nh == 0),
            na > 0, (ns > 0) && (na == ns)};
  endfunction

  function automatic void model_reset();
    m_hreq = '0; m_halted = '0; m_phalt = '0; m_pres = '0; m_ack = '0;
    m_sel = '0; m_nonex = 0; m_err = 0; m_sum = '0;
  endfunction

  function automatic void model_update();
    bit          acc, hit;
    bit [NH-1:0] sel_now, o_hreq, o_halted, o_phalt, o_pres, o_ack;
    cyc++;
    acc = cmd_valid && dmactive;
    for (int i = 0; i < NH; i++)
      sel_now[i] = (cmd_hartsel == 10'(i)) || (cmd_hasel && hawindow[i]);
    o_hreq = m_hreq; o_halted = m_halted; o_phalt = m_phalt; o_pres = m_pres; o_ack = m_ack;
    m_sum = summarize(m_sel, o_halted, o_ack);
    if (acc) begin
      m_sel   = sel_now;
      m_nonex = (cmd_hartsel >= 10'(NH));
    end
    for (int i = 0; i < NH; i++) begin
      hit = acc && sel_now[i];
      if (!dmactive) begin
        m_hreq[i] = 0; m_pres[i] = 0; m_ack[i] = 0; m_phalt[i] = 0;
        m_halted[i] = hart_halted[i];
      end else begin
        if (hit) m_hreq[i] = cmd_haltreq;
        if (o_pres[i]) begin
          if (!hart_halted[i]) begin
            m_pres[i] = 0; m_halted[i] = 0; m_ack[i] = 1;
          end else if (cyc - m_rstart[i] >= T) begin
            m_pres[i] = 0; m_err = 1;
          end
        end else if (o_phalt[i]) begin
          if (hart_halted[i]) begin
            m_phalt[i] = 0; m_halted[i] = 1;
          end else if (!o_hreq[i]) begin
            m_phalt[i] = 0;
          end
        end else if (o_halted[i]) begin
          if (hit && !cmd_haltreq && cmd_resumereq) begin
            m_pres[i] = 1; m_ack[i] = 0; m_rstart[i] = cyc;
          end else if (!hart_halted[i]) begin
            m_halted[i] = 0;
          end
        end else begin
          if (hit && cmd_haltreq)  m_phalt[i] = 1;
          else if (hart_halted[i]) m_halted[i] = 1;
        end
      end
    end
    if (!dmactive) m_err = 0;
  endfunction

  task automatic check_all();
    check("debug_int", 32'(debug_int), 32'(m_hreq));
    check("resume_req", 32'(resume_req), 32'(m_pres));
    check("resumeack", 32'(resumeack), 32'(m_ack));
    check("summary", 32'({anyhalted, allhalted, anyrunning, allrunning, anyresumeack, allresumeack}),
          32'(m_sum));
    check("anynonexistent", 32'(anynonexistent), 32'(m_nonex));
    check("resume_err", 32'(resume_err), 32'(m_err));
    check("cmd_ready", 32'(cmd_ready), 32'(dmactive));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else       model_update();
    #1;
    check_all();
  endtask

  task automatic cmd(input int hs, input bit hasel, input bit [NH-1:0] win, input bit hr, input bit rr);
    cmd_valid = 1; cmd_hartsel = 10'(hs); cmd_hasel = hasel; hawindow = win;
    cmd_haltreq = hr; cmd_resumereq = rr;
    tick();
    cmd_valid = 0; cmd_hasel = 0; cmd_haltreq = 0; cmd_resumereq = 0;
  endtask

  initial begin
    reset = 1; dmactive = 0; cmd_valid = 0; cmd_haltreq = 0; cmd_resumereq = 0;
    cmd_hasel = 0; cmd_hartsel = '0; hawindow = '0; hart_halted = '0;
    model_reset();
    #1;
    check_all();
    check("reset_debug_int", 32'(debug_int), 32'h0);
    repeat (2) tick();
    @(negedge clock); reset = 0;
    dmactive = 1;
    tick();

    // Halt hart 2
    cmd(2, 0, '0, 1, 0);
    check("halt_debug_int", 32'(debug_int), 32'h4);
    hart_halted = 4'b0100;
    repeat (3) tick();
    check("halt_allhalted", 32'(allhalted), 32'h1);
    check("halt_anyrunning", 32'(anyrunning), 32'h0);

    // Resume hart 2
    cmd(2, 0, '0, 0, 1);
    check("resume_req_set", 32'(resume_req), 32'h4);
    check("resumeack_clr", 32'(resumeack[2]), 32'h0);
    repeat (5) tick();
    hart_halted = 4'b0000;
    tick();
    check("resume_req_clr", 32'(resume_req), 32'h0);
    check("resumeack_set", 32'(resumeack), 32'h4);
    tick();
    check("resume_allrunning", 32'(allrunning), 32'h1);

    // Hart-array selection
    cmd(0, 1, 4'b1011, 1, 0);
    check("hasel_debug_int", 32'(debug_int), 32'hB);
    hart_halted = 4'b0011;
    repeat (3) tick();
    check("hasel_anyhalted", 32'(anyhalted), 32'h1);
    check("hasel_allhalted", 32'(allhalted), 32'h0);

    // Nonexistent hart
    cmd(7, 0, '0, 1, 0);
    check("nonex_set", 32'(anynonexistent), 32'h1);
    check("nonex_debug_int", 32'(debug_int), 32'hB);
    tick();
    check("nonex_empty_summary",
          32'({anyhalted, allhalted, anyrunning, allrunning, anyresumeack, allresumeack}), 32'h0);
    cmd(1, 0, '0, 1, 0);
    check("nonex_clr", 32'(anynonexistent), 32'h0);

    // Resume timeout on hart 0, then a successful retry
    cmd(0, 0, '0, 0, 1);
    check("to_req_set", 32'(resume_req[0]), 32'h1);
    repeat (T - 1) tick();
    check("to_req_held", 32'(resume_req[0]), 32'h1);
    tick();
    check("to_req_drop", 32'(resume_req[0]), 32'h0);
    check("to_err", 32'(resume_err), 32'h1);
    tick();
    check("to_halted", 32'(allhalted), 32'h1);
    cmd(0, 0, '0, 0, 1);
    check("retry_req", 32'(resume_req[0]), 32'h1);
    hart_halted[0] = 1'b0;
    tick();
    check("retry_ack", 32'(resumeack[0]), 32'h1);
    check("retry_err_sticky", 32'(resume_err), 32'h1);

    // haltreq wins over resumereq
    cmd(1, 0, '0, 1, 1);
    check("both_no_resume", 32'(resume_req[1]), 32'h0);
    tick();

    // Async reset during RESUME_PEND
    cmd(1, 0, '0, 0, 1);
    check("rst_pre_req", 32'(resume_req[1]), 32'h1);
    @(negedge clock);
    reset = 1;
    model_reset();
    #1;
    check_all();
    check("rst_resume_req", 32'(resume_req), 32'h0);
    @(negedge clock); reset = 0;
    hart_halted = 4'b0001;
    repeat (2) tick();

    // Create a sticky error, then drop dmactive with every hart requested
    cmd(0, 0, '0, 0, 1);
    repeat (T) tick();
    check("pre_off_err", 32'(resume_err), 32'h1);
    cmd(0, 1, 4'b1111, 1, 0);
    check("all_debug_int", 32'(debug_int), 32'hF);
    dmactive = 0;
    tick();
    check("off_debug_int", 32'(debug_int), 32'h0);
    check("off_err", 32'(resume_err), 32'h0);
    check("off_cmd_ready", 32'(cmd_ready), 32'h0);
    dmactive = 1;
    hart_halted = '0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      cmd_valid     = ($urandom_range(0, 2) == 0);
      cmd_hartsel   = 10'($urandom_range(0, 5));
      cmd_hasel     = ($urandom_range(0, 3) == 0);
      hawindow      = NH'($urandom);
      cmd_haltreq   = $urandom_range(0, 1) == 1;
      cmd_resumereq = $urandom_range(0, 1) == 1;
      dmactive      = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NH; i++) begin
        if (m_hreq[i] && !hart_halted[i] && $urandom_range(0, 2) == 0)     hart_halted[i] = 1;
        else if (m_pres[i] && $urandom_range(0, 5) == 0)                  hart_halted[i] = 0;
        else if ($urandom_range(0, 15) == 0)                              hart_halted[i] = ~hart_halted[i];
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
